// File: rtl/laser_link_scheduler_if.sv
// rtl/laser_link_scheduler_if.sv - host, transmitter and receiver signal bundle for laser_link_scheduler
//
// Purpose: groups every non-clock signal of the scheduler into one bundle.
// Ports (slave = scheduler view):
//   host side : in_valid, in_data1, in_data2, in_last (in) / in_ready (out)
//   tx side   : tx_data1, tx_data2, tx_ready, tx_en (out) / tx_done (in)
//   rx side   : rx_valid, rx_data1, rx_data2 (in)
//   status    : pkt_sent, pkt_failed, busy (out)
// The master modport is the environment (host + laser front end).

interface laser_link_scheduler_if;
  logic       in_valid;
  logic [7:0] in_data1;
  logic [7:0] in_data2;
  logic       in_last;
  logic       in_ready;
  logic [7:0] tx_data1;
  logic [7:0] tx_data2;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_en;
  logic       rx_valid;
  logic [7:0] rx_data1;
  logic [7:0] rx_data2;
  logic       pkt_sent;
  logic       pkt_failed;
  logic       busy;

  modport slave (
    input  in_valid, in_data1, in_data2, in_last, tx_done, rx_valid, rx_data1, rx_data2,
    output in_ready, tx_data1, tx_data2, tx_ready, tx_en, pkt_sent, pkt_failed, busy
  );

  modport master (
    output in_valid, in_data1, in_data2, in_last, tx_done, rx_valid, rx_data1, rx_data2,
    input  in_ready, tx_data1, tx_data2, tx_ready, tx_en, pkt_sent, pkt_failed, busy
  );
endinterface

// File: rtl/laser_link_scheduler.sv
// rtl/laser_link_scheduler.sv - packet framer/sequencer with ack, retry and timeout for the dual-laser link
//
// Purpose: buffers host byte pairs into a packet, sends header / payload /
// XOR trailer one pair per transmitter handshake, then waits for an ack and
// retransmits on NACK or timeout up to MAX_RETRY times.
// Ports:
//   clk  : system clock, all state changes on posedge
//   rst  : asynchronous active-high reset
//   link : laser_link_scheduler_if.slave (host, tx, rx and status signals)

module laser_link_scheduler #(
  parameter int PKT_PAIRS = 16,
  parameter int TIMEOUT   = 4096,
  parameter int MAX_RETRY = 3,
  parameter int GAP       = 2
) (
  input logic                   clk,
  input logic                   rst,
  laser_link_scheduler_if.slave link
);

  localparam int AW = (PKT_PAIRS > 1) ? $clog2(PKT_PAIRS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT_TX, GAP_WAIT, WAIT_ACK} state_t;

  state_t        state, state_nx;
  logic [15:0]   buf_mem [0:(1<<AW)-1];
  logic [5:0]    n;
  logic [5:0]    idx;
  logic [2:0]    seq;
  logic [RW-1:0] retries;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    trl1, trl2;
  logic          sent_q, failed_q;

  logic          in_acc, fill_full, gap_done, is_ack, is_nack, tout, retry_ok;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    pair1, pair2;

  assign in_acc    = link.in_valid && (state == IDLE || state == FILL);
  // true when this acceptance brings the count up to PKT_PAIRS
  assign fill_full = (int'(n) + 1 >= PKT_PAIRS);
  assign gap_done  = (int'(gap_cnt) + 1 >= GAP);
  assign is_ack    = link.rx_valid && link.rx_data1 == 8'h5A && link.rx_data2 == {seq, 5'b0};
  assign is_nack   = link.rx_valid && link.rx_data1 == 8'hE1;
  assign tout      = (timer == TW'(TIMEOUT - 1));
  assign retry_ok  = (int'(retries) < MAX_RETRY);
  assign wr_addr   = (state == IDLE) ? '0 : n[AW-1:0];
  assign rd_addr   = AW'(idx - 6'd1);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (in_acc) state_nx = (link.in_last || PKT_PAIRS == 1) ? ISSUE : FILL;
      FILL:     if (in_acc && (link.in_last || fill_full)) state_nx = ISSUE;
      ISSUE:    state_nx = WAIT_TX;
      WAIT_TX:  if (link.tx_done) state_nx = GAP_WAIT;
      GAP_WAIT: if (gap_done) state_nx = (idx <= n) ? ISSUE : WAIT_ACK;
      // ACK is tested first so it wins over a coincident timeout
      WAIT_ACK: begin
        if (is_ack)                state_nx = IDLE;
        else if (is_nack || tout)  state_nx = retry_ok ? ISSUE : IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  // counters, trailer accumulator and result pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n        <= '0;
      idx      <= '0;
      seq      <= '0;
      retries  <= '0;
      timer    <= '0;
      gap_cnt  <= '0;
      trl1     <= '0;
      trl2     <= '0;
      sent_q   <= 1'b0;
      failed_q <= 1'b0;
    end else begin
      sent_q   <= 1'b0;
      failed_q <= 1'b0;
      case (state)
        IDLE: begin
          idx     <= '0;
          retries <= '0;
          if (in_acc) begin
            n    <= 6'd1;
            trl1 <= link.in_data1;
            trl2 <= link.in_data2;
          end
        end
        FILL: begin
          idx     <= '0;
          retries <= '0;
          if (in_acc) begin
            n    <= n + 6'd1;
            trl1 <= trl1 ^ link.in_data1;
            trl2 <= trl2 ^ link.in_data2;
          end
        end
        WAIT_TX: gap_cnt <= '0;
        GAP_WAIT: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_done) begin
            if (idx <= n) idx   <= idx + 6'd1;
            else          timer <= '0;
          end
        end
        WAIT_ACK: begin
          timer <= timer + 1'b1;
          if (is_ack) begin
            sent_q <= 1'b1;
            seq    <= seq + 3'd1;
          end else if (is_nack || tout) begin
            if (retry_ok) begin
              retries <= retries + 1'b1;
              idx     <= '0;
            end else begin
              failed_q <= 1'b1;
              seq      <= seq + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // payload buffer; contents are meaningless until rewritten after reset
  always_ff @(posedge clk) begin
    if (in_acc) buf_mem[wr_addr] <= {link.in_data1, link.in_data2};
  end

  // pair selected by idx: header, payload slot idx-1, or trailer
  always_comb begin
    if (idx == 6'd0) begin
      pair1 = 8'hA5;
      pair2 = {seq, 5'(n - 6'd1)};
    end else if (idx <= n) begin
      {pair1, pair2} = buf_mem[rd_addr];
    end else begin
      pair1 = trl1;
      pair2 = trl2;
    end
  end

  // outputs
  always_comb begin
    link.in_ready   = 1'b0;
    link.tx_ready   = 1'b0;
    link.tx_en      = 1'b0;
    link.tx_data1   = 8'h00;
    link.tx_data2   = 8'h00;
    link.busy       = (state != IDLE);
    link.pkt_sent   = sent_q;
    link.pkt_failed = failed_q;
    case (state)
      IDLE, FILL: link.in_ready = !rst;
      ISSUE, WAIT_TX: begin
        link.tx_en    = 1'b1;
        link.tx_ready = (state == ISSUE);
        link.tx_data1 = pair1;
        link.tx_data2 = pair2;
      end
      GAP_WAIT, WAIT_ACK: link.tx_en = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_laser_link_scheduler.sv
// tb/tb_laser_link_scheduler.sv - directed self-checking bench for laser_link_scheduler

module tb_laser_link_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_rdy = 0;

  laser_link_scheduler_if bus();

  laser_link_scheduler #(
    .PKT_PAIRS(4), .TIMEOUT(16), .MAX_RETRY(3), .GAP(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .link(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic send_pair(input logic [7:0] d1, input logic [7:0] d2, input logic last);
    check("in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data1 = d1;
    bus.in_data2 = d2;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // waits for tx_ready, checks the pair and its spacing, checks it is held, returns done at t+11
  task automatic expect_pair(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                             input int spacing);
    int waited = 0;
    logic stable = 1'b1;
    while (!bus.tx_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_rdy"}, 32'(bus.tx_ready), 1);
    if (bus.tx_ready) begin
      check({tag, "_data"}, 32'({bus.tx_data1, bus.tx_data2}), 32'({e1, e2}));
      if (spacing != 0) check({tag, "_spacing"}, 32'(cyc - last_rdy), 32'(spacing));
      last_rdy = cyc;
      repeat (11) begin
        @(negedge clk);
        if ({bus.tx_data1, bus.tx_data2} !== {e1, e2} || bus.tx_ready !== 1'b0) stable = 1'b0;
      end
      check({tag, "_hold"}, 32'(stable), 1);
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
    end
  endtask

  task automatic drive_rx(input logic [7:0] d1, input logic [7:0] d2);
    bus.rx_valid = 1'b1;
    bus.rx_data1 = d1;
    bus.rx_data2 = d2;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic four_pair_frame(input string tag, input logic [7:0] hdr2, input int first_sp);
    expect_pair({tag, "_hdr"}, 8'hA5, hdr2, first_sp);
    expect_pair({tag, "_p0"},  8'h01, 8'h10, 14);
    expect_pair({tag, "_p1"},  8'h02, 8'h20, 14);
    expect_pair({tag, "_p2"},  8'h03, 8'h30, 14);
    expect_pair({tag, "_p3"},  8'h04, 8'h40, 14);
    expect_pair({tag, "_trl"}, 8'h04, 8'h40, 14);
  endtask

  task automatic one_pair_frame(input string tag, input logic [7:0] hdr2,
                                input logic [7:0] d1, input logic [7:0] d2, input int first_sp);
    expect_pair({tag, "_hdr"}, 8'hA5, hdr2, first_sp);
    expect_pair({tag, "_p0"},  d1, d2, 14);
    expect_pair({tag, "_trl"}, d1, d2, 14);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data1 = 8'h00; bus.in_data2 = 8'h00; bus.in_last = 1'b0;
    bus.tx_done  = 1'b0; bus.rx_valid = 1'b0; bus.rx_data1 = 8'h00; bus.rx_data2 = 8'h00;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_busy",     32'(bus.busy), 0);
    check("rst_tx_ready", 32'(bus.tx_ready), 0);
    check("rst_tx_en",    32'(bus.tx_en), 0);
    check("rst_tx_data",  32'({bus.tx_data1, bus.tx_data2}), 0);
    check("rst_pulses",   32'({bus.pkt_sent, bus.pkt_failed}), 0);
    rst = 1'b0;
    #1 check("post_rst_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);

    // basic packet: full buffer closes the packet without in_last
    send_pair(8'h01, 8'h10, 1'b0);
    send_pair(8'h02, 8'h20, 1'b0);
    send_pair(8'h03, 8'h30, 1'b0);
    send_pair(8'h04, 8'h40, 1'b0);
    check("full_in_ready", 32'(bus.in_ready), 0);
    check("full_tx_en",    32'(bus.tx_en), 1);
    four_pair_frame("basic", 8'h03, 0);
    repeat (3) @(negedge clk);
    check("basic_wait_en", 32'(bus.tx_en), 1);
    drive_rx(8'h5A, 8'h00);
    check("basic_sent", 32'(bus.pkt_sent), 1);
    check("basic_busy", 32'(bus.busy), 0);
    @(negedge clk);
    check("basic_sent_pulse", 32'(bus.pkt_sent), 0);

    // short packet with seq=1
    send_pair(8'hFF, 8'hEE, 1'b1);
    one_pair_frame("short", 8'h20, 8'hFF, 8'hEE, 0);
    repeat (3) @(negedge clk);
    drive_rx(8'h5A, 8'h20);
    check("short_sent", 32'(bus.pkt_sent), 1);

    // NACK retry, seq=2, retransmit starts 16 cycles after the trailer
    send_pair(8'h01, 8'h10, 1'b0);
    send_pair(8'h02, 8'h20, 1'b0);
    send_pair(8'h03, 8'h30, 1'b0);
    send_pair(8'h04, 8'h40, 1'b0);
    four_pair_frame("nack_a", 8'h43, 0);
    repeat (3) @(negedge clk);
    drive_rx(8'hE1, 8'h77);
    check("nack_no_fail", 32'({bus.pkt_sent, bus.pkt_failed}), 0);
    four_pair_frame("nack_b", 8'h43, 16);
    repeat (3) @(negedge clk);
    drive_rx(8'h5A, 8'h40);
    check("nack_sent", 32'(bus.pkt_sent), 1);

    // wrong-seq ACK ignored (timer keeps running), then ACK on the timeout cycle wins
    send_pair(8'h12, 8'h34, 1'b1);
    one_pair_frame("ign_a", 8'h60, 8'h12, 8'h34, 0);
    repeat (7) @(negedge clk);
    drive_rx(8'h5A, 8'h00);
    check("ign_busy", 32'(bus.busy), 1);
    one_pair_frame("ign_b", 8'h60, 8'h12, 8'h34, 30);
    repeat (2) @(negedge clk);
    repeat (15) @(negedge clk);
    check("tout_cycle_en", 32'(bus.tx_en), 1);
    drive_rx(8'h5A, 8'h60);
    check("tout_ack_sent",  32'(bus.pkt_sent), 1);
    check("tout_ack_nordy", 32'(bus.tx_ready), 0);
    check("tout_ack_busy",  32'(bus.busy), 0);

    // timeout exhaustion: four transmissions then pkt_failed
    send_pair(8'h55, 8'hAA, 1'b1);
    one_pair_frame("exh_0", 8'h80, 8'h55, 8'hAA, 0);
    one_pair_frame("exh_1", 8'h80, 8'h55, 8'hAA, 30);
    one_pair_frame("exh_2", 8'h80, 8'h55, 8'hAA, 30);
    one_pair_frame("exh_3", 8'h80, 8'h55, 8'hAA, 30);
    repeat (2) @(negedge clk);
    repeat (15) @(negedge clk);
    check("exh_pre_fail", 32'(bus.pkt_failed), 0);
    @(negedge clk);
    check("exh_failed",   32'(bus.pkt_failed), 1);
    check("exh_not_sent", 32'(bus.pkt_sent), 0);
    check("exh_busy",     32'(bus.busy), 0);
    check("exh_tx_ready", 32'(bus.tx_ready), 0);
    @(negedge clk);
    check("exh_fail_pulse", 32'(bus.pkt_failed), 0);

    // reset mid-packet during WAIT_TX of pair 2
    send_pair(8'h66, 8'h77, 1'b1);
    expect_pair("mid_hdr", 8'hA5, 8'hA0, 0);
    expect_pair("mid_p0_pre", 8'h66, 8'h77, 14);
    // expect_pair above completed pair 2; drive the header again after reset instead
    check("mid_pre_en", 32'(bus.tx_en), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_ready", 32'(bus.tx_ready), 0);
    check("mid_rst_tx_en",    32'(bus.tx_en), 0);
    check("mid_rst_busy",     32'(bus.busy), 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("mid_rel_in_ready", 32'(bus.in_ready), 1);
    check("mid_rel_busy", 32'(bus.busy), 0);
    @(negedge clk);
    send_pair(8'h21, 8'h43, 1'b1);
    one_pair_frame("post", 8'h00, 8'h21, 8'h43, 0);
    repeat (3) @(negedge clk);
    drive_rx(8'h5A, 8'h00);
    check("post_sent", 32'(bus.pkt_sent), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
